// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
//   Shared definitions for the CPU memory port slice. It holds the
//   default parameter values, the FSM state encoding, the wait counter
//   width and a helper that sizes the RAM word index.
package cpu_mem_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DEPTH    = 256;
    localparam int DEF_WAIT_CYC = 0;
    localparam int DEF_ERR_W    = 8;

    // The wait counter covers the legal WAIT_CYC range 0..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Index width for a DEPTH-word array. A single-word array still gets one bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cpu_mem_ram.sv
// cpu_mem_ram
//   DEPTH x DATA_W storage with a synchronous write and a registered read.
//   The read register only loads when i_re is high, so the word read at
//   acceptance stays on o_rdata until the next read. Contents are not reset.
//
// Ports
//   clk     : clock; writes and reads happen on its rising edge
//   i_we    : write enable (the caller guarantees i_addr < DEPTH)
//   i_re    : read enable (the caller guarantees i_addr < DEPTH)
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data
module cpu_mem_ram
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = addr_bits(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_mem_port.sv
// cpu_mem_port
//   Single-outstanding request/response port in front of a small RAM.
//   A request is accepted in IDLE. Optionally it spends WAIT_CYC cycles in
//   WAIT, then the response is presented in RESP until it is taken.
//   Addresses >= DEPTH are flagged as errors: the write is suppressed, the
//   read data is zero and a saturating error counter is bumped.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   req_valid : request present
//   req_ready : request can be accepted this cycle (IDLE and not in reset)
//   req_we    : 1 = write, 0 = read
//   req_addr  : word address
//   req_wdata : write data
//   rsp_valid : response present
//   rsp_ready : consumer takes the response
//   rsp_rdata : read data (0 for writes and errors)
//   rsp_err   : address was out of range
//   err_cnt   : saturating count of errored accesses
module cpu_mem_port
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WAIT_CYC = DEF_WAIT_CYC,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int               RAM_AW   = addr_bits(DEPTH);
    // One extra bit so DEPTH == 2^ADDR_W is representable.
    localparam logic [ADDR_W:0]  LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LP_WAIT  = CNT_W'(WAIT_CYC);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_we;
    logic              r_err;
    logic [ERR_W-1:0]  r_err_cnt;

    logic              w_accept;
    logic              w_oor;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [RAM_AW-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_rdata;

    assign req_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;
    assign w_oor      = ({1'b0, req_addr} >= LP_DEPTH);
    assign w_ram_addr = req_addr[RAM_AW-1:0];
    assign w_ram_we   = w_accept && req_we && !w_oor;
    assign w_ram_re   = w_accept && !req_we && !w_oor;

    // The address is held implicitly by the RAM read register, which
    // captures mem[addr] at acceptance and is not reloaded until the next read.
    cpu_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (req_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYC == 0) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LP_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Leave on the edge where the counter reaches zero, so that
                // RESP starts WAIT_CYC edges after acceptance.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_accept) begin
            r_we  <= req_we;
            r_err <= w_oor;
            if (w_oor && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    // Response fields are gated by RESP, so they read zero outside a response.
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_ram_rdata : '0;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_cpu_mem_port.sv
// tb_cpu_mem_port
//   Directed bench for cpu_mem_port (DATA_W=16, ADDR_W=8, DEPTH=200,
//   WAIT_CYC=2). Stimulus pushes the expected response into a queue; a
//   monitor on the falling edge pops and compares on each response handshake.
module tb_cpu_mem_port;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 8;
    localparam int DEPTH    = 200;
    localparam int WAIT_CYC = 2;
    localparam int ERR_W    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ERR_W-1:0]  err_cnt;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    cpu_mem_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .WAIT_CYC (WAIT_CYC),
        .ERR_W    (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out waiting on DUT (cycle %0d)", name, cyc);
    endtask

    // Scoreboard monitor: a pending response is discarded by reset.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b, expected none", rsp_rdata, rsp_err);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    // Present a request, wait for acceptance, return the acceptance cycle.
    // req_valid is left high so callers can chain requests back to back.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input logic [DATA_W-1:0] exp_rd, input logic exp_err, output int acc);
        int n = 0;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            timeout("accept");
            req_valid = 1'b0;
            acc = cyc;
            return;
        end
        q.push_back('{exp_rd, exp_err});
        @(posedge clk); #1;
        acc = cyc;
    endtask

    // Wait for rsp_valid and check it rose WAIT_CYC edges after acceptance.
    task automatic wait_rsp(input int acc);
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_valid) timeout("rsp_valid");
        else chk("rsp_latency", 32'(cyc - acc), 32'(WAIT_CYC));
    endtask

    task automatic access(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input logic [DATA_W-1:0] exp_rd, input logic exp_err);
        int acc;
        issue(we, addr, wdata, exp_rd, exp_err, acc);
        req_valid = 1'b0;
        wait_rsp(acc);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        int accs[3];
        logic [ADDR_W-1:0] b2b_addr[3];
        logic [DATA_W-1:0] b2b_data[3];

        // Reset values
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 1);

        // Basic write / read back, plus a marker word at 20 and the top word
        access(1'b1, 8'd20, 16'h5A5A, 16'h0000, 1'b0);
        access(1'b1, 8'd100, 16'h1234, 16'h0000, 1'b0);
        access(1'b0, 8'd100, 16'h0000, 16'h1234, 1'b0);
        access(1'b1, 8'd199, 16'h0199, 16'h0000, 1'b0);
        access(1'b0, 8'd199, 16'h0000, 16'h0199, 1'b0);

        // Out of range write / read
        access(1'b1, 8'd220, 16'hBEEF, 16'h0000, 1'b1);
        access(1'b0, 8'd220, 16'h0000, 16'h0000, 1'b1);
        chk("err_cnt_after_220", 32'(err_cnt), 2);
        access(1'b0, 8'd20, 16'h0000, 16'h5A5A, 1'b0);
        access(1'b0, 8'd200, 16'h0000, 16'h0000, 1'b1);
        chk("err_cnt_after_200", 32'(err_cnt), 3);

        // Response stall: outputs hold, new requests are ignored
        rsp_ready = 1'b0;
        issue(1'b0, 8'd100, 16'h0000, 16'h1234, 1'b0, acc);
        req_valid = 1'b0;
        wait_rsp(acc);
        req_we    = 1'b1;
        req_addr  = 8'd100;
        req_wdata = 16'hDEAD;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_rsp_valid", 32'(rsp_valid), 1);
            chk("stall_rsp_rdata", 32'(rsp_rdata), 32'h1234);
            chk("stall_req_ready", 32'(req_ready), 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_idle", 32'(req_ready), 1);
        chk("stall_release_valid", 32'(rsp_valid), 0);
        access(1'b0, 8'd100, 16'h0000, 16'h1234, 1'b0);

        // Back-to-back reads: one acceptance every WAIT_CYC+2 cycles
        b2b_addr[0] = 8'd100; b2b_data[0] = 16'h1234;
        b2b_addr[1] = 8'd20;  b2b_data[1] = 16'h5A5A;
        b2b_addr[2] = 8'd199; b2b_data[2] = 16'h0199;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, b2b_addr[i], 16'h0000, b2b_data[i], 1'b0, accs[i]);
        end
        req_valid = 1'b0;
        chk("b2b_gap_0", 32'(accs[1] - accs[0]), 32'(WAIT_CYC + 2));
        chk("b2b_gap_1", 32'(accs[2] - accs[1]), 32'(WAIT_CYC + 2));
        wait_rsp(accs[2]);
        @(posedge clk); #1;

        // Reset in WAIT after a write: response dropped, write persists
        issue(1'b1, 8'd7, 16'h00FF, 16'h0000, 1'b0, acc);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_req_ready", 32'(req_ready), 0);
        chk("midrst_err_cnt", 32'(err_cnt), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_rsp_valid_hold", 32'(rsp_valid), 0);
        chk("midrst_req_ready_hold", 32'(req_ready), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 8'd7, 16'h0000, 16'h00FF, 1'b0);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            access(1'b0, ADDR_W'(200 + (i % 56)), 16'h0000, 16'h0000, 1'b1);
            if (i == 253) chk("err_cnt_254", 32'(err_cnt), 254);
            if (i == 254) chk("err_cnt_255", 32'(err_cnt), 255);
        end
        chk("err_cnt_sat", 32'(err_cnt), 255);

        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cpu_mem_port.md
CPU_MEM_PORT -- requirements
Module: cpu_mem_port

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning address width.
REQ-003 SHALL have parameter DEPTH, default 256, meaning implemented words; legal range 1..2^ADDR_W.
REQ-004 SHALL have parameter WAIT_CYC, default 0, meaning extra wait states per access; legal range 0..15.
REQ-005 SHALL have parameter ERR_W, default 8, meaning error-counter width.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; it is asynchronous and active-high.
REQ-008 SHALL have port req_valid, input, 1, request present.
REQ-009 SHALL have port req_ready, output, 1, block accepts a request this cycle.
REQ-010 SHALL have port req_we, input, 1, 1=write, 0=read.
REQ-011 SHALL have port req_addr, input, ADDR_W, word address.
REQ-012 SHALL have port req_wdata, input, DATA_W, write data.
REQ-013 SHALL have port rsp_valid, output, 1, response present.
REQ-014 SHALL have port rsp_ready, input, 1, consumer takes the response.
REQ-015 SHALL have port rsp_rdata, output, DATA_W, read data (0 for writes and errors).
REQ-016 SHALL have port rsp_err, output, 1, address >= DEPTH.
REQ-017 SHALL have port err_cnt, output, ERR_W, saturating count of errored accesses.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-019 SHALL drive req_ready = (state==IDLE) and not rst.
REQ-020 SHALL accept at edge E0 when req_valid and req_ready; it SHALL latch we/addr, capture read data mem[addr] and the error flag at E0.
REQ-021 SHALL commit an in-range write to mem[addr] at E0.
REQ-022 SHALL move IDLE->RESP at E0 when WAIT_CYC=0, else IDLE->WAIT with counter loaded to WAIT_CYC.
REQ-023 SHALL decrement the counter each WAIT cycle and go WAIT->RESP when it reaches 0; rsp_valid rises at edge E0+WAIT_CYC.
REQ-024 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid and rsp_ready, then go to IDLE on that edge.
REQ-025 SHALL give a sustained throughput of one access per WAIT_CYC+2 cycles with rsp_ready held high.
REQ-026 SHALL, for addr >= DEPTH, suppress the write, return rsp_rdata=0 and rsp_err=1, and increment err_cnt once at E0.
REQ-027 SHALL saturate err_cnt at 2^ERR_W-1 with no wrap.
REQ-028 SHALL return rsp_rdata=0 for writes.
REQ-029 SHALL ignore req_* inputs outside IDLE; rsp_ready outside RESP SHALL have no effect.

Reset
REQ-030 SHALL on rst force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0, req_ready=0.
REQ-031 SHALL discard any pending response on reset mid-WAIT/RESP; a write already committed at E0 SHALL persist.
REQ-032 SHALL NOT reset memory contents.

Structure
REQ-033 SHALL place the FSM state encoding and default parameter constants in shared package cpu_mem_pkg.
REQ-034 SHALL instantiate a single sub-module cpu_mem_ram (DEPTH x DATA_W synchronous-write, registered-read array); the FSM, counter and error logic stay in cpu_mem_port.

Verification (DATA_W=16, ADDR_W=8, DEPTH=200, WAIT_CYC=2)
REQ-035 SHALL write 0x1234 @100 then read @100 -> rsp_rdata=0x1234, rsp_err=0, rsp_valid rising 2 edges after each acceptance.
REQ-036 SHALL write 0xBEEF @220 then read @220 -> both rsp_err=1, rdata=0, err_cnt=2, and mem[20] unchanged.
REQ-037 SHALL hold rsp_ready=0 for 5 cycles during a read of @100 -> rsp_valid/rdata=0x1234 stable, req_ready=0, then IDLE one edge after rsp_ready=1.
REQ-038 SHALL issue back-to-back reads with req_valid and rsp_ready held high -> acceptances exactly 4 cycles apart.
REQ-039 SHALL assert rst in WAIT after a write of 0x00FF @7 -> rsp_valid=0, req_ready=0 during reset; a subsequent read @7 returns 0x00FF.
REQ-040 SHALL issue 300 out-of-range reads with ERR_W=8 -> err_cnt=255 after the 255th and stays 255.
